// File: rtl/cic_block_param_if.sv
// ---------------------------------------------------------------------------
// cic_block_param_if
//   Groups the lane datapath signals and the cs/we register port of
//   cic_block_param into one bundle.
//
//   Handshake: io_valid_i marks a sample on a rising edge. There is no ready;
//   the cell takes every valid sample while CTRL.en is set. io_valid_o marks
//   the cycle in which io_out/io_co/io_vco carry a result. The data outputs
//   have no meaning when io_valid_o is low.
//
//   Signals
//     io_in1     LANES*W  lane operands, lane k = [k*W +: W]
//     io_ci      LANES    per-lane carry-in (unchained operation)
//     io_valid_i 1        sample valid
//     io_vci     1        chain carry-in into lane 0 (chained operation)
//     io_out     LANES*W  lane results
//     io_co      LANES    per-lane carry-out
//     io_vco     1        carry-out of the top lane when chained, else 0
//     io_valid_o 1        result valid
//     cs_i/we_i  1/1      register select / write enable
//     adr_i      2        register address
//     dat_i      DW       register write data
//     dat_o      DW       register read data (combinational)
//
//   Modports: master drives samples and register accesses; slave is the cell.
// ---------------------------------------------------------------------------
interface cic_block_param_if #(
   parameter int LANES = 8,
   parameter int W     = 8,
   parameter int DW    = 16
);
   logic [LANES*W-1:0] io_in1;
   logic [LANES-1:0]   io_ci;
   logic               io_valid_i;
   logic               io_vci;
   logic [LANES*W-1:0] io_out;
   logic [LANES-1:0]   io_co;
   logic               io_vco;
   logic               io_valid_o;
   logic               cs_i;
   logic               we_i;
   logic [1:0]         adr_i;
   logic [DW-1:0]      dat_i;
   logic [DW-1:0]      dat_o;

   modport master (
      output io_in1, io_ci, io_valid_i, io_vci, cs_i, we_i, adr_i, dat_i,
      input  io_out, io_co, io_vco, io_valid_o, dat_o
   );

   modport slave (
      input  io_in1, io_ci, io_valid_i, io_vci, cs_i, we_i, adr_i, dat_i,
      output io_out, io_co, io_vco, io_valid_o, dat_o
   );
endinterface

// File: rtl/cic_block_param.sv
// ---------------------------------------------------------------------------
// cic_block_param
//   Carry-chain compute cell. LANES lanes of W-bit add / integrate / comb
//   datapath, each with its own carry-in and carry-out. The lanes can be
//   chained into one LANES*W-bit word, in which case the carry ripples from
//   lane 0 upwards in the same cycle. Each lane has a 2-bit mode:
//     00 PASS  res = in1,               co = cin
//     01 ACC   {co,res} = acc+in1+cin,  acc <= res on accept
//     10 DIFF  {co,res} = in1+~prev+cin, prev <= in1 on accept
//     11 HOLD  res = acc,               co = 0
//   Results are either combinational (pipe=0) or registered once (pipe=1).
//
//   Register map (write on rising edge when cs_i & we_i)
//     0 CTRL   [0] en  [1] pipe  [2] chain  [3] clr_acc (action, reads 0)
//     1 MODE   2 bits per lane, lane k = [2k+1:2k]
//     2 STATUS [LANES-1:0] sticky lane carry-outs, write 1 to clear
//     3 COUNT  accepted-sample count, any write clears it
//
//   Ports
//     wb_clk_i  clock, all state on the rising edge
//     wb_rst_i  synchronous active-low reset
//     bus       cic_block_param_if.slave (datapath and register port)
// ---------------------------------------------------------------------------
module cic_block_param #(
   parameter int LANES = 8,
   parameter int W     = 8,
   parameter int DW    = 16
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   cic_block_param_if.slave     bus
);

   localparam logic [1:0] MODE_PASS = 2'b00;
   localparam logic [1:0] MODE_ACC  = 2'b01;
   localparam logic [1:0] MODE_DIFF = 2'b10;

   localparam logic [1:0] ADR_CTRL   = 2'd0;
   localparam logic [1:0] ADR_MODE   = 2'd1;
   localparam logic [1:0] ADR_STATUS = 2'd2;
   localparam logic [1:0] ADR_COUNT  = 2'd3;

   // ------------------------------------------------------------------
   // Configuration and state
   // ------------------------------------------------------------------
   logic                 ctrl_en;
   logic                 ctrl_pipe;
   logic                 ctrl_chain;
   logic [2*LANES-1:0]   mode_q;
   logic [LANES-1:0]     status_q;
   logic [DW-1:0]        count_q;
   logic [LANES*W-1:0]   acc_q;
   logic [LANES*W-1:0]   prev_q;

   // Registered result stage used when pipe=1
   logic [LANES*W-1:0]   out_q;
   logic [LANES-1:0]     co_q;
   logic                 vco_q;
   logic                 valid_q;

   // ------------------------------------------------------------------
   // Register port decode
   // ------------------------------------------------------------------
   logic                 wr;
   logic                 wr_ctrl;
   logic                 wr_mode;
   logic                 wr_status;
   logic                 wr_count;
   logic                 clr_acc;
   logic                 accept;
   logic [LANES-1:0]     w1c_mask;
   logic [LANES-1:0]     set_mask;

   assign wr        = bus.cs_i & bus.we_i;
   assign wr_ctrl   = wr & (bus.adr_i == ADR_CTRL);
   assign wr_mode   = wr & (bus.adr_i == ADR_MODE);
   assign wr_status = wr & (bus.adr_i == ADR_STATUS);
   assign wr_count  = wr & (bus.adr_i == ADR_COUNT);

   // clr_acc acts on the write edge itself rather than after it, so the
   // accumulators are already zero for the first sample after the write.
   assign clr_acc   = wr_ctrl & bus.dat_i[3];

   assign accept    = bus.io_valid_i & ctrl_en;

   // ------------------------------------------------------------------
   // Lane datapath
   //   carry holds the carry-out of the lane just evaluated, so in chained
   //   mode lane k sees lane k-1's carry within the same evaluation.
   // ------------------------------------------------------------------
   logic [LANES*W-1:0]   res_c;
   logic [LANES-1:0]     co_c;
   logic                 vco_c;
   logic [LANES*W-1:0]   acc_d;
   logic [LANES*W-1:0]   prev_d;
   logic                 carry;
   logic                 cin;
   logic [W:0]           sum;

   always_comb begin
      res_c  = '0;
      co_c   = '0;
      acc_d  = acc_q;
      prev_d = prev_q;
      carry  = bus.io_vci;
      cin    = 1'b0;
      sum    = '0;
      for (int k = 0; k < LANES; k++) begin
         cin = ctrl_chain ? carry : bus.io_ci[k];
         case (mode_q[2*k +: 2])
            MODE_PASS: sum = {cin, bus.io_in1[k*W +: W]};
            MODE_ACC:  sum = {1'b0, acc_q[k*W +: W]}
                           + {1'b0, bus.io_in1[k*W +: W]}
                           + {{W{1'b0}}, cin};
            // in1 + ~prev + 1 is in1 - prev; co=1 means no borrow
            MODE_DIFF: sum = {1'b0, bus.io_in1[k*W +: W]}
                           + {1'b0, ~prev_q[k*W +: W]}
                           + {{W{1'b0}}, cin};
            default:   sum = {1'b0, acc_q[k*W +: W]};
         endcase
         res_c[k*W +: W] = sum[W-1:0];
         co_c[k]         = sum[W];
         carry           = sum[W];
         if (mode_q[2*k +: 2] == MODE_ACC) begin
            acc_d[k*W +: W] = sum[W-1:0];
         end
         if (mode_q[2*k +: 2] == MODE_DIFF) begin
            prev_d[k*W +: W] = bus.io_in1[k*W +: W];
         end
      end
      vco_c = ctrl_chain & carry;
   end

   // Set wins over a same-cycle write-1-to-clear.
   assign w1c_mask = wr_status ? bus.dat_i[LANES-1:0] : '0;
   assign set_mask = accept ? co_c : '0;

   // ------------------------------------------------------------------
   // State update
   // ------------------------------------------------------------------
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         ctrl_en    <= 1'b0;
         ctrl_pipe  <= 1'b0;
         ctrl_chain <= 1'b0;
         mode_q     <= '0;
         status_q   <= '0;
         count_q    <= '0;
         acc_q      <= '0;
         prev_q     <= '0;
         out_q      <= '0;
         co_q       <= '0;
         vco_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            ctrl_en    <= bus.dat_i[0];
            ctrl_pipe  <= bus.dat_i[1];
            ctrl_chain <= bus.dat_i[2];
         end
         if (wr_mode) begin
            mode_q <= bus.dat_i[2*LANES-1:0];
         end

         status_q <= (status_q & ~w1c_mask) | set_mask;

         // A write clears COUNT even if a sample is accepted that cycle.
         if (wr_count) begin
            count_q <= '0;
         end else if (accept) begin
            count_q <= count_q + DW'(1);
         end

         // Clearing wins over the accept update; the outputs of this cycle
         // were already formed from the old acc/prev.
         if (clr_acc) begin
            acc_q  <= '0;
            prev_q <= '0;
         end else if (accept) begin
            acc_q  <= acc_d;
            prev_q <= prev_d;
         end

         // Output stage only loads on an accept while pipelined and holds
         // otherwise, so the last result stays visible after valid drops.
         valid_q <= accept & ctrl_pipe;
         if (accept & ctrl_pipe) begin
            out_q <= res_c;
            co_q  <= co_c;
            vco_q <= vco_c;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.io_out     = ctrl_pipe ? out_q   : res_c;
   assign bus.io_co      = ctrl_pipe ? co_q    : co_c;
   assign bus.io_vco     = ctrl_pipe ? vco_q   : vco_c;
   assign bus.io_valid_o = ctrl_pipe ? valid_q : accept;

   logic [DW-1:0] rd_data;

   always_comb begin
      rd_data = '0;
      case (bus.adr_i)
         ADR_CTRL:   rd_data[2:0]         = {ctrl_chain, ctrl_pipe, ctrl_en};
         ADR_MODE:   rd_data[2*LANES-1:0] = mode_q;
         ADR_STATUS: rd_data[LANES-1:0]   = status_q;
         default:    rd_data              = count_q;
      endcase
      bus.dat_o = bus.cs_i ? rd_data : '0;
   end

endmodule

// File: tb/tb_cic_block_param.sv
// ---------------------------------------------------------------------------
// tb_cic_block_param
//   Directed scenarios followed by randomized traffic. A behavioural model
//   computes each lane's result with integer arithmetic and tracks the
//   register contents; every cycle the DUT outputs and read data are compared
//   against it. Key scenarios also compare against fixed expected values.
// ---------------------------------------------------------------------------
module tb_cic_block_param;

   localparam int LANES = 8;
   localparam int W     = 8;
   localparam int DW    = 16;

   // ------------------------------------------------------------------
   // Clock / reset
   // ------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   cic_block_param_if #(.LANES(LANES), .W(W), .DW(DW)) bus ();

   cic_block_param #(.LANES(LANES), .W(W), .DW(DW)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst_n),
      .bus      (bus)
   );

   int n_vec     = 0;
   int n_miscmp  = 0;

   // ------------------------------------------------------------------
   // Reference model state
   // ------------------------------------------------------------------
   bit        m_en, m_pipe, m_chain;
   bit [15:0] m_mode;
   int        m_acc  [LANES];
   int        m_prev [LANES];
   bit [7:0]  m_status;
   bit [15:0] m_count;
   bit [63:0] m_oq;
   bit [7:0]  m_coq;
   bit        m_vcoq;
   bit        m_vq;

   // Values seen on the DUT at the last sample point
   logic [63:0] obs_out;
   logic [7:0]  obs_co;
   logic        obs_vco;
   logic        obs_valid;
   logic [15:0] obs_dat;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miscmp++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_en = 0; m_pipe = 0; m_chain = 0; m_mode = '0;
      m_status = '0; m_count = '0;
      m_oq = '0; m_coq = '0; m_vcoq = 0; m_vq = 0;
      for (int k = 0; k < LANES; k++) begin
         m_acc[k]  = 0;
         m_prev[k] = 0;
      end
   endtask

   // Lane results from the current model state and the given inputs.
   task automatic model_eval(input bit [63:0] in1, input bit [7:0] ci, input bit vci,
                             output bit [63:0] o, output bit [7:0] co, output bit vco);
      int c, a, cin, s, r, y, md;
      o = '0; co = '0; c = int'(vci);
      for (int k = 0; k < LANES; k++) begin
         a   = int'(in1[k*8 +: 8]);
         cin = m_chain ? c : int'(ci[k]);
         md  = int'(m_mode[2*k +: 2]);
         case (md)
            0: begin r = a; y = cin; end
            1: begin s = m_acc[k] + a + cin; r = s % 256; y = s / 256; end
            2: begin s = a + (255 - m_prev[k]) + cin; r = s % 256; y = s / 256; end
            default: begin r = m_acc[k]; y = 0; end
         endcase
         o[k*8 +: 8] = 8'(r);
         co[k]       = y[0];
         c           = y;
      end
      vco = m_chain ? c[0] : 1'b0;
   endtask

   function automatic bit [15:0] model_read(input bit [1:0] adr);
      case (adr)
         2'd0:    return {13'b0, m_chain, m_pipe, m_en};
         2'd1:    return m_mode;
         2'd2:    return {8'b0, m_status};
         default: return m_count;
      endcase
   endfunction

   // ------------------------------------------------------------------
   // Driver: one clock cycle. Inputs change at the falling edge, outputs are
   // compared 1 ns later, the model advances at the rising edge.
   // ------------------------------------------------------------------
   task automatic cycle(input bit rst, input bit [63:0] in1, input bit [7:0] ci,
                        input bit valid, input bit vci, input bit cs, input bit we,
                        input bit [1:0] adr, input bit [15:0] dat);
      bit [63:0] eo;
      bit [7:0]  eco;
      bit        evco, acc_ok;
      bit [7:0]  nst;
      rst_n          = rst;
      bus.io_in1     = in1;
      bus.io_ci      = ci;
      bus.io_valid_i = valid;
      bus.io_vci     = vci;
      bus.cs_i       = cs;
      bus.we_i       = we;
      bus.adr_i      = adr;
      bus.dat_i      = dat;
      #1;
      model_eval(in1, ci, vci, eo, eco, evco);
      acc_ok    = valid & m_en;
      obs_out   = bus.io_out;
      obs_co    = bus.io_co;
      obs_vco   = bus.io_vco;
      obs_valid = bus.io_valid_o;
      obs_dat   = bus.dat_o;
      if (rst) begin
         chk("valid_o", 64'(obs_valid), 64'(m_pipe ? m_vq : acc_ok));
         chk("out",     64'(obs_out),   64'(m_pipe ? m_oq : eo));
         chk("co",      64'(obs_co),    64'(m_pipe ? m_coq : eco));
         chk("vco",     64'(obs_vco),   64'(m_pipe ? m_vcoq : evco));
         chk("dat_o",   64'(obs_dat),   64'(cs ? model_read(adr) : 16'h0));
      end
      @(posedge clk);
      if (!rst) begin
         model_reset();
      end else begin
         if (acc_ok) begin
            for (int k = 0; k < LANES; k++) begin
               if (m_mode[2*k +: 2] == 2'd1) m_acc[k]  = int'(eo[k*8 +: 8]);
               if (m_mode[2*k +: 2] == 2'd2) m_prev[k] = int'(in1[k*8 +: 8]);
            end
            m_count = m_count + 16'd1;
         end
         nst = m_status;
         if (cs && we && adr == 2'd2) nst = nst & ~dat[7:0];
         if (acc_ok) nst = nst | eco;
         m_status = nst;
         if (acc_ok && m_pipe) begin
            m_oq = eo; m_coq = eco; m_vcoq = evco;
         end
         m_vq = acc_ok & m_pipe;
         if (cs && we) begin
            case (adr)
               2'd0: begin
                  m_en = dat[0]; m_pipe = dat[1]; m_chain = dat[2];
                  if (dat[3]) begin
                     for (int k = 0; k < LANES; k++) begin
                        m_acc[k] = 0; m_prev[k] = 0;
                     end
                  end
               end
               2'd1: m_mode = dat;
               2'd3: m_count = '0;
               default: ;
            endcase
         end
      end
      @(negedge clk);
   endtask

   task automatic wr(input bit [1:0] adr, input bit [15:0] dat);
      cycle(1, '0, '0, 0, 0, 1, 1, adr, dat);
   endtask

   task automatic rd(input bit [1:0] adr);
      cycle(1, '0, '0, 0, 0, 1, 0, adr, '0);
   endtask

   task automatic smp(input bit [63:0] in1, input bit [7:0] ci, input bit vci);
      cycle(1, in1, ci, 1, vci, 0, 0, 2'd0, '0);
   endtask

   task automatic idle();
      cycle(1, '0, '0, 0, 0, 0, 0, 2'd0, '0);
   endtask

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      bit [7:0]  s0;
      bit [63:0] r_in;
      bit [15:0] r_dat;
      bit [1:0]  r_adr;
      bit        r_wr;
      model_reset();
      rst_n = 1'b0;
      @(negedge clk);

      // Reset held while a CTRL write and a sample are presented
      cycle(0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1, 1, 1, 1, 2'd0, 16'h0001);
      cycle(0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1, 1, 1, 1, 2'd0, 16'h0001);
      for (int a = 0; a < 4; a++) begin
         rd(2'(a));
         chk($sformatf("reset_reg%0d", a), 64'(obs_dat), 64'h0);
      end
      chk("reset_valid_o", 64'(obs_valid), 64'h0);
      chk("reset_vco", 64'(obs_vco), 64'h0);

      // Lane 0 accumulator
      wr(2'd0, 16'h0001);
      wr(2'd1, 16'h0001);
      smp(64'h80, 8'h00, 0);
      chk("acc_s1_out", 64'(obs_out[7:0]), 64'h80);
      chk("acc_s1_co",  64'(obs_co[0]),    64'h0);
      smp(64'h80, 8'h00, 0);
      chk("acc_s2_out", 64'(obs_out[7:0]), 64'h00);
      chk("acc_s2_co",  64'(obs_co[0]),    64'h1);
      smp(64'h80, 8'h00, 0);
      chk("acc_s3_out", 64'(obs_out[7:0]), 64'h80);
      chk("acc_s3_co",  64'(obs_co[0]),    64'h0);
      rd(2'd2);
      chk("acc_status", 64'(obs_dat), 64'h01);
      rd(2'd3);
      chk("acc_count", 64'(obs_dat), 64'd3);
      wr(2'd2, 16'h0001);
      rd(2'd2);
      chk("status_w1c", 64'(obs_dat), 64'h00);

      // 64-bit chained difference
      wr(2'd0, 16'h0005);
      wr(2'd1, 16'hAAAA);
      smp(64'h0, 8'h00, 1);
      chk("diff1_out", 64'(obs_out), 64'h0);
      chk("diff1_vco", 64'(obs_vco), 64'h1);
      smp(64'h1, 8'h00, 1);
      chk("diff2_out", 64'(obs_out), 64'h1);
      chk("diff2_vco", 64'(obs_vco), 64'h1);
      smp(64'h0, 8'h00, 1);
      chk("diff3_out", 64'(obs_out), 64'hFFFF_FFFF_FFFF_FFFF);
      chk("diff3_vco", 64'(obs_vco), 64'h0);

      // Pipelined pass-through
      wr(2'd0, 16'h0003);
      wr(2'd1, 16'h0000);
      smp(64'h5A00_0000, 8'h00, 0);
      chk("pipe_lat0_valid", 64'(obs_valid), 64'h0);
      idle();
      chk("pipe_lat1_valid", 64'(obs_valid), 64'h1);
      chk("pipe_lat1_out",   64'(obs_out[31:24]), 64'h5A);
      idle();
      chk("pipe_hold_valid", 64'(obs_valid), 64'h0);
      chk("pipe_hold_out",   64'(obs_out[31:24]), 64'h5A);

      // clr_acc and COUNT write colliding with an accept
      wr(2'd0, 16'h0009);
      wr(2'd1, 16'h0001);
      smp(64'h10, 8'h00, 0);
      cycle(1, 64'h05, 8'h00, 1, 0, 1, 1, 2'd0, 16'h0009);
      chk("clr_same_cycle", 64'(obs_out[7:0]), 64'h15);
      smp(64'h01, 8'h00, 0);
      chk("clr_next", 64'(obs_out[7:0]), 64'h01);
      cycle(1, 64'h0, 8'h00, 1, 0, 1, 1, 2'd3, 16'h1234);
      rd(2'd3);
      chk("count_wr_beats_inc", 64'(obs_dat), 64'h0);

      // Disabled cell ignores samples
      wr(2'd0, 16'h0000);
      s0 = m_status;
      for (int i = 0; i < 4; i++) begin
         smp({$urandom, $urandom}, 8'($urandom), 1'($urandom));
         chk("disabled_valid", 64'(obs_valid), 64'h0);
      end
      rd(2'd3);
      chk("disabled_count", 64'(obs_dat), 64'h0);
      rd(2'd2);
      chk("disabled_status", 64'(obs_dat), 64'(s0));

      // Randomized traffic against the model
      wr(2'd0, 16'h0001);
      for (int i = 0; i < 600; i++) begin
         r_in  = {$urandom, $urandom};
         r_wr  = ($urandom_range(0, 7) == 0);
         r_adr = 2'($urandom_range(0, 3));
         r_dat = 16'($urandom);
         if (r_adr == 2'd0) begin
            r_dat = 16'($urandom_range(0, 15));
            if ($urandom_range(0, 4) != 0) r_dat[0] = 1'b1;
         end
         cycle(1, r_in, 8'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
               1'($urandom), r_wr, r_adr, r_dat);
      end

      // Reset mid-run overrides a same-cycle write and accept
      cycle(0, 64'h1, 8'h1, 1, 1, 1, 1, 2'd1, 16'hFFFF);
      for (int a = 0; a < 4; a++) begin
         rd(2'(a));
         chk($sformatf("rerst_reg%0d", a), 64'(obs_dat), 64'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
